// File: rtl/draw_board_rows.sv
// -----------------------------------------------------------------------------
// draw_board_rows
//
// Redraws a range of board rows from the board RAM onto the VGA pixel port,
// one pixel per clock. Each board cell is drawn as a CELL x CELL square of
// pixels (CELL = 1 << CELL_LOG2). The hidden rows at the top of the board are
// never drawn. In clear mode every plotted pixel gets colour 0.
//
// The pixel coordinates are computed when the RAM address is issued. They
// travel through a RAM_LATENCY-deep pipeline so that they reach the VGA port
// in the same cycle as the matching RAM data.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high
//   start      one-cycle draw request, sampled only while busy = 0
//   row_first  first board row to draw (inclusive, clamped to the visible rows)
//   row_last   last board row to draw (inclusive, clamped to the board)
//   clear      latched at start; 1 = draw colour 0 instead of RAM data
//   ram_addr   board RAM read address = row*BOARD_W + col
//   ram_q      board RAM data, valid RAM_LATENCY cycles after ram_addr
//   X, Y       pixel coordinates
//   colour     pixel colour (0 when plot = 0)
//   plot       pixel write strobe for the VGA adapter
//   busy       high from the accepted start until done
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module draw_board_rows #(
    parameter int BOARD_W     = 10,
    parameter int BOARD_H     = 24,
    parameter int HIDDEN_ROWS = 4,
    parameter int CELL_LOG2   = 2,
    parameter int X_START     = 0,
    parameter int Y_START     = 0,
    parameter int COLOUR_W    = 6,
    parameter int ADDR_W      = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4:0]          row_first,
    input  logic [4:0]          row_last,
    input  logic                clear,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [COLOUR_W-1:0] ram_q,
    output logic [7:0]          X,
    output logic [6:0]          Y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int OFF_W = 2 * CELL_LOG2;
    localparam int COL_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;

    localparam logic [4:0]       HID_ROW    = 5'(HIDDEN_ROWS);
    localparam logic [4:0]       LAST_ROW   = 5'(BOARD_H - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(BOARD_W - 1);
    localparam logic [OFF_W-1:0] OFF_LAST   = {OFF_W{1'b1}};
    localparam logic [1:0]       DRAIN_LAST = 2'(RAM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t           state, state_n;
    logic [4:0]       row, row_n;
    logic [4:0]       hi, hi_n;
    logic [COL_W-1:0] col, col_n;
    logic [OFF_W-1:0] off, off_n;
    logic [1:0]       drain_cnt, drain_n;
    logic             clear_q, clear_n;
    logic             issue;

    // Requested range clamped to the visible part of the board.
    logic [4:0] row_lo, row_hi;
    assign row_lo = (row_first < HID_ROW)  ? HID_ROW  : row_first;
    assign row_hi = (row_last  > LAST_ROW) ? LAST_ROW : row_last;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            row       <= '0;
            hi        <= '0;
            col       <= '0;
            off       <= '0;
            drain_cnt <= '0;
            clear_q   <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            hi        <= hi_n;
            col       <= col_n;
            off       <= off_n;
            drain_cnt <= drain_n;
            clear_q   <= clear_n;
        end
    end

    // ------------------------------------------------------------------
    // Next state and scan counters
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement. This
        // way no path leaves a value unassigned, and no latch is inferred.
        state_n = state;
        row_n   = row;
        hi_n    = hi;
        col_n   = col;
        off_n   = off;
        drain_n = drain_cnt;
        clear_n = clear_q;
        issue   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    hi_n    = row_hi;
                    clear_n = clear;
                    row_n   = row_lo;
                    col_n   = '0;
                    off_n   = '0;
                    // An empty range after clamping still completes the handshake.
                    state_n = (row_lo > row_hi) ? S_FINISH : S_SCAN;
                end
            end

            S_SCAN: begin
                issue = 1'b1;
                off_n = off + 1'b1;
                if (off == OFF_LAST) begin
                    if (col == COL_LAST) begin
                        col_n = '0;
                        if (row == hi) begin
                            state_n = S_DRAIN;
                            drain_n = '0;
                        end else begin
                            row_n = row + 1'b1;
                        end
                    end else begin
                        col_n = col + 1'b1;
                    end
                end
            end

            // Let the last RAM_LATENCY pixels leave the pipeline before done.
            S_DRAIN: begin
                drain_n = drain_cnt + 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_n = S_FINISH;
                end
            end

            S_FINISH: state_n = S_IDLE;

            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_FINISH);

    // Board RAM address. It is truncated to ADDR_W bits and is never range-checked.
    assign ram_addr = ADDR_W'(32'(row) * 32'(BOARD_W) + 32'(col));

    // ------------------------------------------------------------------
    // Pixel coordinates at address issue.
    // off[CELL_LOG2-1:0] is the x offset inside the cell and
    // off[OFF_W-1:CELL_LOG2] is the y offset.
    // ------------------------------------------------------------------
    logic [7:0] issue_x;
    logic [6:0] issue_y;
    assign issue_x = 8'(X_START) + (8'(col) << CELL_LOG2) + 8'(off[CELL_LOG2-1:0]);
    assign issue_y = 7'(Y_START) + (7'(row - HID_ROW) << CELL_LOG2)
                   + 7'(off[OFF_W-1:CELL_LOG2]);

    // ------------------------------------------------------------------
    // Coordinate pipeline, aligned with the RAM read latency.
    // ------------------------------------------------------------------
    logic       pipe_v [RAM_LATENCY];
    logic [7:0] pipe_x [RAM_LATENCY];
    logic [6:0] pipe_y [RAM_LATENCY];

    // NOTE: the pipeline is small, so all of it is reset. This includes the
    // coordinate stages, which hold the documented X=0 and Y=0 reset values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
            end
        end else begin
            pipe_v[0] <= issue;
            pipe_x[0] <= issue_x;
            pipe_y[0] <= issue_y;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_x[i] <= pipe_x[i-1];
                pipe_y[i] <= pipe_y[i-1];
            end
        end
    end

    assign plot   = pipe_v[RAM_LATENCY-1];
    assign X      = pipe_x[RAM_LATENCY-1];
    assign Y      = pipe_y[RAM_LATENCY-1];
    assign colour = (plot && !clear_q) ? ram_q : '0;

endmodule

// File: tb/tb_draw_board_rows.sv
// -----------------------------------------------------------------------------
// tb_draw_board_rows
//
// Drives two instances of draw_board_rows:
//   dut_a : default parameters (10x24 board, 4-pixel cells, RAM latency 1)
//   dut_b : BOARD_W=6, CELL_LOG2=3, RAM_LATENCY=2
// Each instance has a RAM model that returns ram_q = addr[5:0] after the
// configured latency.
// -----------------------------------------------------------------------------
module tb_draw_board_rows;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start_b = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] row_first = 5'd0;
    logic [4:0] row_last = 5'd0;

    logic [7:0] addr_a, x_a, addr_b, x_b;
    logic [6:0] y_a, y_b;
    logic [5:0] q_a, col_a, q_b1, q_b2, col_b;
    logic       plot_a, busy_a, done_a, plot_b, busy_b, done_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    draw_board_rows dut_a (
        .clk(clk), .reset(reset), .start(start), .row_first(row_first),
        .row_last(row_last), .clear(clear), .ram_addr(addr_a), .ram_q(q_a),
        .X(x_a), .Y(y_a), .colour(col_a), .plot(plot_a), .busy(busy_a),
        .done(done_a)
    );

    draw_board_rows #(.BOARD_W(6), .CELL_LOG2(3), .RAM_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .row_first(row_first),
        .row_last(row_last), .clear(clear), .ram_addr(addr_b), .ram_q(q_b2),
        .X(x_b), .Y(y_b), .colour(col_b), .plot(plot_b), .busy(busy_b),
        .done(done_b)
    );

    // Board RAM models: data = address[5:0]
    always @(posedge clk) begin
        q_a  <= addr_a[5:0];
        q_b1 <= addr_b[5:0];
        q_b2 <= q_b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0] rf;
        logic [4:0] rl;
        logic       clr;
        bit         inj;   // extra start pulses mid-scan and at done
        int         lo;    // expected clamped first row
        int         n;     // expected plot count
    } vec_t;

    vec_t vecs[7];

    // Values that run_a records for the per-vector checks
    int first_x, first_y, first_c, last_x, last_y, last_c;
    int min_addr, last_addr, min_y, max_y;

    // Runs one draw on dut_a. The caller is at a negedge with busy_a = 0.
    // The task returns at the negedge one cycle after done.
    task automatic run_a(input vec_t v, input string tag);
        int k, n, first_k, last_k, done_k, gaps, pix_bad, hs_bad;
        int er, ec, eo, ex, ey, ecol;
        start = 1'b1; row_first = v.rf; row_last = v.rl; clear = v.clr;
        @(negedge clk);
        // Inputs other than start may change freely after the start cycle.
        start = 1'b0; row_first = 5'd0; row_last = 5'd31; clear = ~v.clr;
        k = 1; n = 0; first_k = -1; last_k = -1; done_k = -1;
        gaps = 0; pix_bad = 0; hs_bad = 0;
        er = v.lo; ec = 0; eo = 0;
        min_addr = 9999; last_addr = -1; min_y = 9999; max_y = -1;
        while (done_k < 0 && k < 5000) begin
            if (k <= v.n) begin
                if (int'(addr_a) < min_addr) min_addr = int'(addr_a);
                last_addr = int'(addr_a);
            end
            if (plot_a) begin
                if (first_k < 0) begin
                    first_k = k;
                    first_x = int'(x_a); first_y = int'(y_a); first_c = int'(col_a);
                end else if (last_k != k - 1) begin
                    gaps++;
                end
                last_k = k;
                last_x = int'(x_a); last_y = int'(y_a); last_c = int'(col_a);
                if (int'(y_a) < min_y) min_y = int'(y_a);
                if (int'(y_a) > max_y) max_y = int'(y_a);
                ex   = ec * 4 + eo % 4;
                ey   = (er - 4) * 4 + eo / 4;
                ecol = v.clr ? 0 : (er * 10 + ec) % 64;
                if (int'(x_a) != ex || int'(y_a) != ey || int'(col_a) != ecol)
                    pix_bad++;
                n++;
                eo++;
                if (eo == 16) begin
                    eo = 0; ec++;
                    if (ec == 10) begin ec = 0; er++; end
                end
            end
            if (!busy_a) hs_bad++;
            if (done_a) begin
                done_k = k;
                if (plot_a) hs_bad++;
            end
            if (v.inj && k == 40) begin start = 1'b1; row_first = 5'd4; row_last = 5'd23; end
            if (v.inj && k == 41) start = 1'b0;
            if (done_k < 0) begin
                @(negedge clk);
                k++;
            end
        end
        // A start in the same cycle as done must be ignored.
        if (v.inj && done_k >= 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " plot count"}, n, v.n);
        check({tag, " first plot cycle"}, first_k, (v.n > 0) ? 2 : -1);
        check({tag, " plot gaps"}, gaps, 0);
        check({tag, " done cycle"}, done_k, (v.n > 0) ? v.n + 2 : 1);
        check({tag, " pixel mismatches"}, pix_bad, 0);
        check({tag, " busy/done errors"}, hs_bad, 0);
        check({tag, " busy after done"}, int'(busy_a), 0);
        check({tag, " done after done"}, int'(done_a), 0);
    endtask

    initial begin
        int k, cnt, activity, first_k, done_k, align_bad, gaps, last_k;

        vecs[0] = '{rf: 5'd4,  rl: 5'd4,  clr: 1'b0, inj: 1'b0, lo: 4,  n: 160};
        vecs[1] = '{rf: 5'd0,  rl: 5'd31, clr: 1'b0, inj: 1'b0, lo: 4,  n: 3200};
        vecs[2] = '{rf: 5'd10, rl: 5'd11, clr: 1'b1, inj: 1'b0, lo: 10, n: 320};
        vecs[3] = '{rf: 5'd9,  rl: 5'd5,  clr: 1'b0, inj: 1'b0, lo: 9,  n: 0};
        vecs[4] = '{rf: 5'd0,  rl: 5'd3,  clr: 1'b0, inj: 1'b0, lo: 4,  n: 0};
        vecs[5] = '{rf: 5'd6,  rl: 5'd7,  clr: 1'b0, inj: 1'b1, lo: 6,  n: 320};
        vecs[6] = '{rf: 5'd23, rl: 5'd23, clr: 1'b0, inj: 1'b0, lo: 23, n: 160};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset X", int'(x_a), 0);
        check("reset Y", int'(y_a), 0);
        check("reset colour", int'(col_a), 0);
        check("reset plot", int'(plot_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset done", int'(done_a), 0);
        check("reset ram_addr", int'(addr_a), 0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven draws. Each one starts in the cycle after busy drops.
        for (int i = 0; i < 7; i++) begin
            run_a(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                check("vec0 first X", first_x, 0);
                check("vec0 first Y", first_y, 0);
                check("vec0 first colour", first_c, 40);
                check("vec0 last X", last_x, 39);
                check("vec0 last Y", last_y, 3);
                check("vec0 last colour", last_c, 49);
            end
            if (i == 1) begin
                check("vec1 min ram_addr", min_addr, 40);
                check("vec1 last ram_addr", last_addr, 239);
                check("vec1 last X", last_x, 39);
                check("vec1 last Y", last_y, 79);
            end
            if (i == 2) begin
                check("vec2 min Y", min_y, 24);
                check("vec2 max Y", max_y, 31);
            end
        end

        // dut_b: latency 2, 8-pixel cells, 6 columns, one row
        start_b = 1'b1; row_first = 5'd4; row_last = 5'd4; clear = 1'b0;
        @(negedge clk);
        start_b = 1'b0;
        k = 1; cnt = 0; first_k = -1; done_k = -1; align_bad = 0; gaps = 0; last_k = -1;
        while (done_k < 0 && k < 2000) begin
            if (plot_b) begin
                if (first_k < 0) first_k = k;
                else if (last_k != k - 1) gaps++;
                last_k = k;
                if (int'(col_b) != (((int'(y_b) / 8) + 4) * 6 + int'(x_b) / 8) % 64)
                    align_bad++;
                cnt++;
            end
            if (done_b) done_k = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        @(negedge clk);
        check("lat2 plot count", cnt, 384);
        check("lat2 first plot cycle", first_k, 3);
        check("lat2 plot gaps", gaps, 0);
        check("lat2 done cycle", done_k, 387);
        check("lat2 colour alignment", align_bad, 0);

        // Reset asserted at the 50th plot
        start = 1'b1; row_first = 5'd4; row_last = 5'd4; clear = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; k = 0;
        while (cnt < 50 && k < 200) begin
            if (plot_a) cnt++;
            if (cnt < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("abort plot index", cnt, 50);
        reset = 1'b1;
        @(negedge clk);
        check("abort plot", int'(plot_a), 0);
        check("abort busy", int'(busy_a), 0);
        check("abort done", int'(done_a), 0);
        reset = 1'b0;
        activity = 0;
        repeat (200) begin
            @(negedge clk);
            if (plot_a || done_a || busy_a) activity++;
        end
        check("activity after abort", activity, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
